cell_hist_reader: RTL and testbench

CELL_HIST_READER -- requirements
Module: cell_hist_reader

---
 rtl/cell_hist_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_cell_hist_reader.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_hist_reader.sv
// Streams 2x2-cell block histograms out of four interleaved cell banks, one bin per beat.
// Read returns land in a small credit-managed FIFO, so backpressure never drops data.
module cell_hist_reader #(
    parameter int CELL_ROWS       = 34,
    parameter int CELL_COLS       = 34,
    parameter int NBINS           = 18,
    parameter int TOTAL_BIT_WIDTH = 35,
    parameter int RD_LAT          = 2
) (
    input  logic                       aclk,
    input  logic                       arest_n,
    input  logic                       histogram_done,
    output logic [12:0]                normal_addra_0,
    output logic [12:0]                normal_addra_1,
    output logic [12:0]                normal_addra_2,
    output logic [12:0]                normal_addra_3,
    input  logic [TOTAL_BIT_WIDTH-1:0] douta_0,
    input  logic [TOTAL_BIT_WIDTH-1:0] douta_1,
    input  logic [TOTAL_BIT_WIDTH-1:0] douta_2,
    input  logic [TOTAL_BIT_WIDTH-1:0] douta_3,
    output logic [TOTAL_BIT_WIDTH-1:0] feat_0,
    output logic [TOTAL_BIT_WIDTH-1:0] feat_1,
    output logic [TOTAL_BIT_WIDTH-1:0] feat_2,
    output logic [TOTAL_BIT_WIDTH-1:0] feat_3,
    output logic [4:0]                 feat_bin,
    output logic                       feat_valid,
    input  logic                       feat_ready,
    output logic                       feat_last,
    output logic                       busy,
    output logic                       write_feature_done
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int PW    = $clog2(DEPTH);
    localparam int CNTW  = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(CELL_ROWS);
    localparam int CW    = $clog2(CELL_COLS);

    localparam logic [RW-1:0]   LAST_BR  = RW'(CELL_ROWS - 2);
    localparam logic [CW-1:0]   LAST_BC  = CW'(CELL_COLS - 2);
    localparam logic [4:0]      LAST_BIN = 5'(NBINS - 1);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CNTW:0]   DEPTH_C  = (CNTW + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                     r_state, w_state_next;
    logic [RW-1:0]              r_br;
    logic [CW-1:0]              r_bc;
    logic [4:0]                 r_bin;
    logic                       w_issue, w_last_issue, w_credit, w_push, w_pop;
    logic [CNTW:0]              w_inflight;

    logic [RD_LAT-1:0]          r_pipe_vld;
    logic [1:0]                 r_pipe_par  [RD_LAT];
    logic [4:0]                 r_pipe_bin  [RD_LAT];
    logic                       r_pipe_last [RD_LAT];

    logic [TOTAL_BIT_WIDTH-1:0] r_mem      [DEPTH][4];
    logic [4:0]                 r_mem_bin  [DEPTH];
    logic                       r_mem_last [DEPTH];
    logic [PW-1:0]              r_wr_ptr, r_rd_ptr;
    logic [CNTW-1:0]            r_count;

    logic [12:0]                w_addr [4];
    logic [TOTAL_BIT_WIDTH-1:0] w_dout [4];

    function automatic logic [12:0] cell_addr(input int r, input int c, input int bin);
        return 13'(((r / 2) * (CELL_COLS / 2) + (c / 2)) * NBINS + bin);
    endfunction

    assign w_dout[0] = douta_0;
    assign w_dout[1] = douta_1;
    assign w_dout[2] = douta_2;
    assign w_dout[3] = douta_3;

    // Bank b holds the block cell whose row/col parity is b; its offset in the block is b ^ parity.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_addr[b] = '0;
            if (w_issue) begin
                w_addr[b] = cell_addr(int'(r_br) + ((b / 2) ^ int'(r_br[0])),
                                      int'(r_bc) + ((b % 2) ^ int'(r_bc[0])), int'(r_bin));
            end
        end
    end

    assign normal_addra_0 = w_addr[0];
    assign normal_addra_1 = w_addr[1];
    assign normal_addra_2 = w_addr[2];
    assign normal_addra_3 = w_addr[3];

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + (CNTW + 1)'(r_pipe_vld[i]);
        end
    end

    assign w_credit     = (w_inflight + (CNTW + 1)'(r_count)) < DEPTH_C;
    assign w_last_issue = (r_br == LAST_BR) && (r_bc == LAST_BC) && (r_bin == LAST_BIN);
    assign w_push       = r_pipe_vld[RD_LAT-1];
    assign w_pop        = feat_valid && feat_ready;

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (histogram_done) w_state_next = StRun;
            StRun:   if (w_issue && w_last_issue) w_state_next = StDrain;
            StDrain: begin
                if (w_inflight == '0 &&
                    (r_count == '0 || (r_count == CNTW'(1) && w_pop))) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_issue            = 1'b0;
        busy               = 1'b0;
        write_feature_done = 1'b0;
        unique case (r_state)
            StIdle:  ;
            StRun: begin
                busy    = 1'b1;
                w_issue = w_credit;
            end
            StDrain: busy = 1'b1;
            StDone: begin
                busy               = 1'b1;
                write_feature_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_br  <= '0;
            r_bc  <= '0;
            r_bin <= '0;
        end else if (w_issue) begin
            if (r_bin == LAST_BIN) begin
                r_bin <= '0;
                if (r_bc == LAST_BC) begin
                    r_bc <= '0;
                    r_br <= (r_br == LAST_BR) ? '0 : r_br + 1'b1;
                end else begin
                    r_bc <= r_bc + 1'b1;
                end
            end else begin
                r_bin <= r_bin + 1'b1;
            end
        end
    end

    // Tag pipeline tracks each read until its bank data is valid.
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe_par[i]  <= '0;
                r_pipe_bin[i]  <= '0;
                r_pipe_last[i] <= 1'b0;
            end
        end else begin
            r_pipe_vld[0]  <= w_issue;
            r_pipe_par[0]  <= {r_br[0], r_bc[0]};
            r_pipe_bin[0]  <= r_bin;
            r_pipe_last[0] <= w_last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_par[i]  <= r_pipe_par[i-1];
                r_pipe_bin[i]  <= r_pipe_bin[i-1];
                r_pipe_last[i] <= r_pipe_last[i-1];
            end
        end
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_push) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[r_wr_ptr][k] <= w_dout[2'(k) ^ r_pipe_par[RD_LAT-1]];
            end
            r_mem_bin[r_wr_ptr]  <= r_pipe_bin[RD_LAT-1];
            r_mem_last[r_wr_ptr] <= r_pipe_last[RD_LAT-1];
        end
    end

    assign feat_valid = (r_count != '0);
    assign feat_0     = feat_valid ? r_mem[r_rd_ptr][0] : '0;
    assign feat_1     = feat_valid ? r_mem[r_rd_ptr][1] : '0;
    assign feat_2     = feat_valid ? r_mem[r_rd_ptr][2] : '0;
    assign feat_3     = feat_valid ? r_mem[r_rd_ptr][3] : '0;
    assign feat_bin   = feat_valid ? r_mem_bin[r_rd_ptr] : '0;
    assign feat_last  = feat_valid & r_mem_last[r_rd_ptr];

endmodule

// File: tb/tb_cell_hist_reader.sv
// Bench for cell_hist_reader: behavioural BRAM banks plus an expected-beat queue built
// from the cell/bank/address mapping, popped as beats transfer.
`timescale 1ns/1ps
module tb_cell_hist_reader;

    localparam int CELL_ROWS = 4;
    localparam int CELL_COLS = 4;
    localparam int NBINS     = 2;
    localparam int TW        = 35;
    localparam int RD_LAT    = 2;
    localparam int BEATS     = (CELL_ROWS - 1) * (CELL_COLS - 1) * NBINS;
    localparam int BUDGET    = 200;

    typedef logic [TW-1:0] word_t;
    typedef struct packed {
        word_t      f3;
        word_t      f2;
        word_t      f1;
        word_t      f0;
        logic [4:0] bin;
        logic       last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        arest_n;
    logic        histogram_done;
    logic [12:0] normal_addra_0, normal_addra_1, normal_addra_2, normal_addra_3;
    word_t       douta_0, douta_1, douta_2, douta_3;
    word_t       feat_0, feat_1, feat_2, feat_3;
    logic [4:0]  feat_bin;
    logic        feat_valid, feat_ready, feat_last, busy, write_feature_done;

    int          n_checks = 0;
    int          n_errors = 0;
    beat_t       sb[$];
    logic [7:0]  salt;

    int          beats, first_t, last_t, wfd_n, wfd_t;
    logic        busy_at [BUDGET];
    int          cap_addr [4];
    logic        r_stalled;
    beat_t       held;

    always #5 aclk = ~aclk;

    cell_hist_reader #(
        .CELL_ROWS       (CELL_ROWS),
        .CELL_COLS       (CELL_COLS),
        .NBINS           (NBINS),
        .TOTAL_BIT_WIDTH (TW),
        .RD_LAT          (RD_LAT)
    ) dut (
        .aclk               (aclk),
        .arest_n            (arest_n),
        .histogram_done     (histogram_done),
        .normal_addra_0     (normal_addra_0),
        .normal_addra_1     (normal_addra_1),
        .normal_addra_2     (normal_addra_2),
        .normal_addra_3     (normal_addra_3),
        .douta_0            (douta_0),
        .douta_1            (douta_1),
        .douta_2            (douta_2),
        .douta_3            (douta_3),
        .feat_0             (feat_0),
        .feat_1             (feat_1),
        .feat_2             (feat_2),
        .feat_3             (feat_3),
        .feat_bin           (feat_bin),
        .feat_valid         (feat_valid),
        .feat_ready         (feat_ready),
        .feat_last          (feat_last),
        .busy               (busy),
        .write_feature_done (write_feature_done)
    );

    function automatic word_t bank_word(input logic [7:0] s, input int b, input int a);
        logic [1:0]  bb;
        logic [12:0] aa;
        bb = b[1:0];
        aa = a[12:0];
        return {s, bb, 12'h000, aa};
    endfunction

    function automatic int cell_addr(input int r, input int c, input int bin);
        return ((r / 2) * (CELL_COLS / 2) + (c / 2)) * NBINS + bin;
    endfunction

    function automatic int cell_bank(input int r, input int c);
        return (r % 2) * 2 + (c % 2);
    endfunction

    // Four banks with RD_LAT cycles of address-to-data latency.
    logic [12:0] addr_arr [4];
    word_t       bpipe [4][RD_LAT];
    assign addr_arr[0] = normal_addra_0;
    assign addr_arr[1] = normal_addra_1;
    assign addr_arr[2] = normal_addra_2;
    assign addr_arr[3] = normal_addra_3;
    always @(posedge aclk) begin
        for (int b = 0; b < 4; b++) begin
            bpipe[b][0] <= bank_word(salt, b, int'(addr_arr[b]));
            for (int s = 1; s < RD_LAT; s++) bpipe[b][s] <= bpipe[b][s-1];
        end
    end
    assign douta_0 = bpipe[0][RD_LAT-1];
    assign douta_1 = bpipe[1][RD_LAT-1];
    assign douta_2 = bpipe[2][RD_LAT-1];
    assign douta_3 = bpipe[3][RD_LAT-1];

    task automatic push_image();
        beat_t e;
        for (int br = 0; br <= CELL_ROWS - 2; br++)
            for (int bc = 0; bc <= CELL_COLS - 2; bc++)
                for (int bin = 0; bin < NBINS; bin++) begin
                    e.f0   = bank_word(salt, cell_bank(br, bc), cell_addr(br, bc, bin));
                    e.f1   = bank_word(salt, cell_bank(br, bc + 1), cell_addr(br, bc + 1, bin));
                    e.f2   = bank_word(salt, cell_bank(br + 1, bc), cell_addr(br + 1, bc, bin));
                    e.f3   = bank_word(salt, cell_bank(br + 1, bc + 1),
                                       cell_addr(br + 1, bc + 1, bin));
                    e.bin  = 5'(bin);
                    e.last = (br == CELL_ROWS - 2) && (bc == CELL_COLS - 2) && (bin == NBINS - 1);
                    sb.push_back(e);
                end
    endtask

    // Called at each negedge: checks stall hold, picks feat_ready, pops on transfer.
    task automatic monitor_cycle(input int t, input int mode);
        beat_t got, exp;
        got = {feat_3, feat_2, feat_1, feat_0, feat_bin, feat_last};
        if (r_stalled) begin
            n_checks++;
            if (!feat_valid || got !== held) begin
                n_errors++;
                $display("FAIL stall_hold t=%0d: got valid=%0b %h, required valid=1 %h",
                         t, feat_valid, got, held);
            end
        end
        case (mode)
            1:       feat_ready = 1'($urandom_range(0, 1));
            2:       feat_ready = (t >= 6 && t < 26) ? 1'b0 : 1'($urandom_range(0, 1));
            default: feat_ready = 1'b1;
        endcase
        if (feat_valid) begin
            if (first_t < 0) first_t = t;
            if (feat_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL extra_beat t=%0d: got %h, required no beat", t, got);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        n_errors++;
                        $display("FAIL beat%0d t=%0d: got %h, required %h", beats, t, got, exp);
                    end
                end
                beats++;
                last_t = t;
            end
        end
        r_stalled = feat_valid && !feat_ready;
        held      = got;
        if (write_feature_done) begin
            wfd_n++;
            wfd_t = t;
        end
        if (t < BUDGET) busy_at[t] = busy;
        if (t == 9) begin
            cap_addr[0] = int'(normal_addra_0);
            cap_addr[1] = int'(normal_addra_1);
            cap_addr[2] = int'(normal_addra_2);
            cap_addr[3] = int'(normal_addra_3);
        end
    endtask

    // Leaves the bench at the negedge just after the edge that samples histogram_done.
    task automatic start_image();
        push_image();
        beats = 0; first_t = -1; last_t = -1; wfd_n = 0; wfd_t = -1; r_stalled = 1'b0;
        for (int i = 0; i < 4; i++) cap_addr[i] = -1;
        @(negedge aclk);
        histogram_done = 1'b1;
        @(negedge aclk);
        histogram_done = 1'b0;
    endtask

    task automatic run_image(input int mode, input bit extra_pulses);
        start_image();
        for (int t = 0; t < BUDGET; t++) begin
            monitor_cycle(t, mode);
            histogram_done = extra_pulses && (t == 4 || t == 10);
            if (wfd_n > 0 && t >= wfd_t + 4) break;
            @(negedge aclk);
        end
        histogram_done = 1'b0;
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({feat_valid, feat_last, busy, write_feature_done} !== 4'b0 ||
            {normal_addra_0, normal_addra_1, normal_addra_2, normal_addra_3} !== '0 ||
            {feat_0, feat_1, feat_2, feat_3} !== '0 || feat_bin !== 5'd0) begin
            n_errors++;
            $display("FAIL %s: got v=%0b l=%0b busy=%0b wfd=%0b bin=%0d a=%0d/%0d/%0d/%0d, required all 0",
                     name, feat_valid, feat_last, busy, write_feature_done, feat_bin,
                     normal_addra_0, normal_addra_1, normal_addra_2, normal_addra_3);
        end
    endtask

    task automatic test_reset();
        arest_n = 1'b0; histogram_done = 1'b0; feat_ready = 1'b0; salt = 8'h11;
        repeat (3) @(negedge aclk);
        check_outputs_zero("reset_outputs");
        arest_n = 1'b1;
        repeat (3) @(negedge aclk);
        check_outputs_zero("idle_after_release");
    endtask

    task automatic test_stream();
        int exp_addr [4];
        exp_addr = '{7, 5, 3, 1};
        salt = 8'h22;
        run_image(0, 1'b0);
        n_checks++;
        if (first_t != RD_LAT + 1) begin
            n_errors++; $display("FAIL first_valid_latency: got %0d, required %0d", first_t, RD_LAT + 1);
        end
        n_checks++;
        if (beats != BEATS) begin
            n_errors++; $display("FAIL stream_beats: got %0d, required %0d", beats, BEATS);
        end
        n_checks++;
        if (last_t - first_t != BEATS - 1) begin
            n_errors++; $display("FAIL back_to_back: got span %0d, required %0d", last_t - first_t, BEATS - 1);
        end
        n_checks++;
        if (wfd_n != 1 || wfd_t != last_t + 1) begin
            n_errors++; $display("FAIL wfd_timing: got n=%0d t=%0d, required n=1 t=%0d", wfd_n, wfd_t, last_t + 1);
        end
        if (wfd_t >= 0 && wfd_t + 1 < BUDGET) begin
            n_checks++;
            if (busy_at[wfd_t] !== 1'b1 || busy_at[wfd_t + 1] !== 1'b0) begin
                n_errors++;
                $display("FAIL busy_drop: got %0b%0b, required 10", busy_at[wfd_t], busy_at[wfd_t + 1]);
            end
        end
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (cap_addr[b] != exp_addr[b]) begin
                n_errors++; $display("FAIL addr_blk11_bank%0d: got %0d, required %0d", b, cap_addr[b], exp_addr[b]);
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++; $display("FAIL stream_leftover: got %0d, required 0", sb.size());
        end
        check_outputs_zero("idle_after_stream");
    endtask

    task automatic test_backpressure();
        for (int m = 1; m <= 2; m++) begin
            salt = 8'(8'h30 + m);
            run_image(m, 1'b0);
            n_checks++;
            if (beats != BEATS || sb.size() != 0 || wfd_n != 1) begin
                n_errors++;
                $display("FAIL backpressure_mode%0d: got beats=%0d left=%0d wfd=%0d, required %0d/0/1",
                         m, beats, sb.size(), wfd_n, BEATS);
            end
        end
    endtask

    task automatic test_ignore_restart();
        salt = 8'h44;
        run_image(0, 1'b1);
        n_checks++;
        if (beats != BEATS || wfd_n != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL ignore_restart: got beats=%0d wfd=%0d left=%0d, required %0d/1/0",
                     beats, wfd_n, sb.size(), BEATS);
        end
    endtask

    task automatic test_reset_midscan();
        int stale;
        salt = 8'h55;
        start_image();
        for (int t = 0; t < BUDGET; t++) begin
            monitor_cycle(t, 0);
            if (beats == 6) break;
            @(negedge aclk);
        end
        n_checks++;
        if (beats != 6) begin
            n_errors++; $display("FAIL reach_beat7: got %0d beats, required 6", beats);
        end
        @(negedge aclk);
        arest_n = 1'b0;
        #1;
        check_outputs_zero("async_reset_midscan");
        sb.delete();
        r_stalled = 1'b0;
        repeat (3) @(negedge aclk);
        arest_n = 1'b1;
        salt = 8'h66;
        stale = 0;
        repeat (6) begin
            @(negedge aclk);
            if (feat_valid || busy) stale++;
        end
        n_checks++;
        if (stale != 0) begin
            n_errors++; $display("FAIL stale_after_reset: got %0d active cycles, required 0", stale);
        end
        run_image(0, 1'b0);
        n_checks++;
        if (beats != BEATS || wfd_n != 1 || first_t != RD_LAT + 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL restart_image: got beats=%0d wfd=%0d first=%0d, required %0d/1/%0d",
                     beats, wfd_n, first_t, BEATS, RD_LAT + 1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_ignore_restart();
        test_reset_midscan();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
